// File: rtl/tia_playfield_pkg.sv
// Shared constants and state encoding for the playfield bit-select sequencer.
package tia_playfield_pkg;

    localparam int NUM_BITS_DEF     = 20;
    localparam int CLKS_PER_BIT_DEF = 4;

    // Cell index map: 0..3 = PF0 bits 4..7, 4..11 = PF1, 12..19 = PF2
    localparam int PF0_BASE = 0;
    localparam int PF1_BASE = 4;
    localparam int PF2_BASE = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } pf_state_e;

endpackage

// File: rtl/tia_playfield_prescaler.sv
// Mod-CLKS_PER_BIT colour-clock divider; wrap marks the last clock of a bit period.
module tia_playfield_prescaler #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign wrap = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr || wrap)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/tia_playfield_scan.sv
// Single-clock playfield scan: walks a one-hot select across the left half, then the
// right half in normal or mirrored order, with the gated playfield bit registered alongside.
module tia_playfield_scan
    import tia_playfield_pkg::*;
#(
    parameter int NUM_BITS     = NUM_BITS_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int IDX_W        = $clog2(NUM_BITS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                reflect,
    input  logic [NUM_BITS-1:0] pf_bits,
    output logic [NUM_BITS-1:0] sel,
    output logic                pf_out,
    output logic                right_half,
    output logic                active,
    output logic                line_done
);

    pf_state_e           state, state_nx;
    logic [IDX_W-1:0]    idx, idx_nx, eff_nx;
    logic                refl_q, refl_nx, done_nx;
    logic                wrap, last;
    logic [NUM_BITS-1:0] sel_nx;

    tia_playfield_prescaler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start),
        .en      (state != ST_IDLE),
        .wrap    (wrap)
    );

    // Outputs are registered from the next-state view so sel and pf_out change on the same edge as state.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        refl_nx  = refl_q;
        done_nx  = 1'b0;
        last     = (idx == IDX_W'(NUM_BITS - 1));
        if (start) begin
            state_nx = ST_LEFT;
            idx_nx   = '0;
        end else begin
            case (state)
                ST_LEFT: if (wrap) begin
                    if (last) begin
                        state_nx = ST_RIGHT;
                        idx_nx   = '0;
                        refl_nx  = reflect;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
                ST_RIGHT: if (wrap) begin
                    if (last) begin
                        state_nx = ST_IDLE;
                        idx_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
                ST_IDLE: ;
                default: state_nx = ST_IDLE;
            endcase
        end
        eff_nx = (state_nx == ST_RIGHT && refl_nx) ? IDX_W'(NUM_BITS - 1) - idx_nx : idx_nx;
        for (int i = 0; i < NUM_BITS; i++)
            sel_nx[i] = (state_nx != ST_IDLE) && (eff_nx == IDX_W'(i));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            refl_q     <= 1'b0;
            sel        <= '0;
            pf_out     <= 1'b0;
            right_half <= 1'b0;
            active     <= 1'b0;
            line_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            refl_q     <= refl_nx;
            sel        <= sel_nx;
            pf_out     <= |(sel_nx & pf_bits);
            right_half <= (state_nx == ST_RIGHT);
            active     <= (state_nx != ST_IDLE);
            line_done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_tia_playfield_scan.sv
// Randomized bench for tia_playfield_scan against a cycles-since-start reference model.
module tb_tia_playfield_scan;

    localparam int NB   = 20;
    localparam int CPB  = 4;
    localparam int HALF = NB * CPB;

    logic          clk = 1'b0;
    logic          reset_n, start, reflect;
    logic [NB-1:0] pf_bits;
    logic [NB-1:0] sel;
    logic          pf_out, right_half, active, line_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: position within the line counted in colour clocks since start
    bit m_run, m_rq, m_done, m_pf;
    int m_n;

    tia_playfield_scan dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .reflect    (reflect),
        .pf_bits    (pf_bits),
        .sel        (sel),
        .pf_out     (pf_out),
        .right_half (right_half),
        .active     (active),
        .line_done  (line_done)
    );

    always #5 clk = ~clk;

    function automatic int bit_of(input int n, input bit rq);
        int k;
        k = ((n - 1) % HALF) / CPB;
        return (n > HALF && rq) ? (NB - 1 - k) : k;
    endfunction

    always @(posedge clk) begin
        int  nn;
        bit  nr, nq, nd;
        if (!reset_n) begin
            m_run <= 1'b0; m_n <= 0; m_rq <= 1'b0; m_done <= 1'b0; m_pf <= 1'b0;
        end else begin
            nr = m_run; nn = m_n; nq = m_rq; nd = 1'b0;
            if (start) begin
                nr = 1'b1; nn = 1;
            end else if (m_run) begin
                nn = m_n + 1;
                if (nn == HALF + 1) nq = reflect;
                if (nn == 2 * HALF + 1) begin nr = 1'b0; nd = 1'b1; end
            end
            m_run  <= nr;
            m_n    <= nn;
            m_rq   <= nq;
            m_done <= nd;
            m_pf   <= nr ? pf_bits[bit_of(nn, nq)] : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [NB-1:0] es;
        if (chk_en) begin
            es = '0;
            if (m_run) es[bit_of(m_n, m_rq)] = 1'b1;
            chk("sel", 32'(sel), 32'(es));
            chk("pf_out", 32'(pf_out), 32'(m_pf));
            chk("active", 32'(active), 32'(m_run));
            chk("right_half", 32'(right_half), 32'(m_run && m_n > HALF));
            chk("line_done", 32'(line_done), 32'(m_done));
        end
    end

    task automatic drv(input bit st, input bit rf, input logic [NB-1:0] pb, input bit rn);
        @(negedge clk);
        start = st; reflect = rf; pf_bits = pb; reset_n = rn;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; reflect = 1'b0; pf_bits = '0;
        @(negedge clk);
        chk_en = 1'b1;
        // reset wins over start, then a long idle stretch
        drv(1, 0, '0, 0);
        for (int i = 0; i < 200; i++) drv(0, 1'($urandom), NB'($urandom), 1);
        // normal line, single lit cell 0
        drv(1, 0, 20'h00001, 1);
        for (int c = 1; c <= 170; c++) drv(0, 0, 20'h00001, 1);
        // reflected line, single lit cell 19: mirror seam
        drv(1, 1, 20'h80000, 1);
        for (int c = 1; c <= 170; c++) drv(0, 1, 20'h80000, 1);
        // reflect raised only after the transition sample
        drv(1, 0, NB'($urandom), 1);
        for (int c = 1; c <= 170; c++) drv(0, c > 80, NB'($urandom), 1);
        // restart mid left half
        drv(1, 0, NB'($urandom), 1);
        for (int c = 1; c <= 220; c++) drv(c == 50, 0, NB'($urandom), 1);
        // restart on the cycle line_done would fire
        drv(1, 1, NB'($urandom), 1);
        for (int c = 1; c <= 170; c++) drv(c == 160, 1, NB'($urandom), 1);
        // reset mid right half, then a clean line
        drv(1, 0, NB'($urandom), 1);
        for (int c = 1; c <= 100; c++) drv(0, 1'($urandom), NB'($urandom), c != 90);
        drv(1, 0, NB'($urandom), 1);
        for (int c = 1; c <= 170; c++) drv(0, 1'($urandom), NB'($urandom), 1);
        // random soak
        for (int i = 0; i < 3000; i++)
            drv($urandom_range(0, 149) == 0, 1'($urandom),
                ($urandom_range(0, 7) == 0) ? NB'($urandom) : pf_bits,
                $urandom_range(0, 999) != 0);
        drv(0, 0, '0, 1);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
